// File: rtl/vadd_stream_pkg.sv
// Shared definitions for the streaming vector add/subtract block.
package vadd_stream_pkg;

  // Width of one fp32 lane inside a stream beat.
  localparam int LANE_W = 32;

  // Sequencer states: wait for start, issue beats, drain results, report done.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vadd_stream_fifo.sv
// Synchronous output FIFO holding operator results until the master stream
// accepts them. Writes into a full FIFO and reads from an empty FIFO are ignored.
module vadd_stream_fifo
  import vadd_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     ap_clk,
  input  logic                     areset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign wr_ok   = wr_en && (count != FULL_CNT);
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge ap_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; a simultaneous read and write keeps count unchanged.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vadd_stream_seq.sv
// Streaming lane-wise add/subtract sequencer. Pairs beats from streams a and b,
// issues them to an external fixed-latency arithmetic pipeline, and returns the
// results on stream c through a credit-protected output FIFO.
//
// Handshake: a beat moves on any stream in a cycle where tvalid and tready are
// both high. Slave tready is only raised when a, b and FIFO credit are all
// available, so both input streams always advance together with op_valid.
module vadd_stream_seq
  import vadd_stream_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int NUM_LANES          = C_AXIS_TDATA_WIDTH / LANE_W,
  parameter int C_LEN_WIDTH        = 32,
  parameter int OP_LATENCY         = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            ap_start,
  input  logic [C_LEN_WIDTH-1:0]          cfg_length,
  input  logic                            cfg_sub,
  output logic                            ap_idle,
  output logic                            ap_done,
  output logic                            ap_ready,
  output logic                            status_len_err,
  input  logic                            s_axis_a_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_a_tdata,
  output logic                            s_axis_a_tready,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_a_tkeep,
  input  logic                            s_axis_a_tlast,
  input  logic                            s_axis_b_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_b_tdata,
  output logic                            s_axis_b_tready,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_b_tkeep,
  input  logic                            s_axis_b_tlast,
  output logic                            m_axis_c_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_c_tdata,
  input  logic                            m_axis_c_tready,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_c_tkeep,
  output logic                            m_axis_c_tlast,
  output logic                            op_valid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   op_a,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   op_b,
  output logic                            op_sub,
  input  logic                            res_valid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   res_data
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int DISC_W = $clog2(OP_LATENCY + 1);
  localparam int KEEP_W = NUM_LANES * (LANE_W / 8);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  state_t                  state;
  state_t                  state_nxt;
  logic                    start_q;
  logic                    start_acc;
  logic [C_LEN_WIDTH-1:0]  len_q;
  logic                    sub_q;
  logic [C_LEN_WIDTH-1:0]  issue_cnt;
  logic [C_LEN_WIDTH-1:0]  issue_num;
  logic [C_LEN_WIDTH-1:0]  out_cnt;
  logic [C_LEN_WIDTH-1:0]  out_num;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [DISC_W-1:0]       discard_cnt;
  logic                    has_credit;
  logic                    issue;
  logic                    last_issue;
  logic                    res_accept;
  logic                    out_fire;
  logic                    unused_keep;

  // Input tkeep carries no information for full-width fp32 beats.
  assign unused_keep = ^{s_axis_a_tkeep, s_axis_b_tkeep};

  // Occupancy plus results still in the pipeline must leave room in the FIFO.
  assign has_credit = ({1'b0, fifo_count} + {1'b0, in_flight}) < DEPTH_L;
  assign start_acc  = (state == ST_IDLE) && ap_start && !start_q;
  assign issue      = (state == ST_RUN) && s_axis_a_tvalid && s_axis_b_tvalid
                      && has_credit && !areset;
  assign issue_num  = issue_cnt + C_LEN_WIDTH'(1);
  assign last_issue = (issue_num == len_q);
  assign out_num    = out_cnt + C_LEN_WIDTH'(1);
  // Results right after a reset belong to a cancelled run and are dropped.
  assign res_accept = res_valid && (discard_cnt == '0) && (in_flight != '0) && !areset;
  assign out_fire   = m_axis_c_tvalid && m_axis_c_tready;

  assign s_axis_a_tready = issue;
  assign s_axis_b_tready = issue;
  assign op_valid        = issue;
  assign op_a            = s_axis_a_tdata;
  assign op_b            = s_axis_b_tdata;
  assign op_sub          = sub_q;

  assign m_axis_c_tvalid = !fifo_empty && !areset;
  assign m_axis_c_tkeep  = {KEEP_W{1'b1}};
  assign m_axis_c_tlast  = m_axis_c_tvalid && (out_num == len_q);

  assign ap_idle  = (state == ST_IDLE) || areset;
  assign ap_done  = (state == ST_DONE) && !areset;
  assign ap_ready = ap_done;

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_acc) state_nxt = (cfg_length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_fire && m_axis_c_tlast) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register, run configuration, beat counters and length-error flag.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state          <= ST_IDLE;
      start_q        <= 1'b0;
      len_q          <= '0;
      sub_q          <= 1'b0;
      issue_cnt      <= '0;
      out_cnt        <= '0;
      status_len_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= ap_start;
      if (start_acc) begin
        len_q          <= cfg_length;
        sub_q          <= cfg_sub;
        issue_cnt      <= '0;
        out_cnt        <= '0;
        status_len_err <= 1'b0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_num;
          if ((s_axis_a_tlast != last_issue) || (s_axis_b_tlast != last_issue))
            status_len_err <= 1'b1;
        end
        if (out_fire) out_cnt <= out_num;
      end
    end
  end

  // Outstanding-result counter and post-reset discard window.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      in_flight   <= '0;
      discard_cnt <= DISC_W'(OP_LATENCY);
    end else begin
      case ({issue, res_accept})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: ;
      endcase
      if (discard_cnt != '0) discard_cnt <= discard_cnt - DISC_W'(1);
    end
  end

  vadd_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_AXIS_TDATA_WIDTH)
  ) u_fifo (
    .ap_clk  (ap_clk),
    .areset  (areset),
    .wr_en   (res_accept),
    .wr_data (res_data),
    .rd_en   (out_fire),
    .rd_data (m_axis_c_tdata),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_vadd_stream_seq.sv
// Bench for vadd_stream_seq: drives both input streams from queues, models the
// external 4-cycle lane-wise add/sub pipeline, and scoreboards stream c.
module tb_vadd_stream_seq;

  localparam int W = 64;
  localparam int K = W / 8;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic areset = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic          ap_start = 1'b0;
  logic [31:0]   cfg_length = '0;
  logic          cfg_sub = 1'b0;
  logic          ap_idle, ap_done, ap_ready, status_len_err;
  logic          s_axis_a_tvalid = 1'b0, s_axis_a_tlast = 1'b0;
  logic [W-1:0]  s_axis_a_tdata = '0;
  logic [K-1:0]  s_axis_a_tkeep = '1;
  logic          s_axis_a_tready;
  logic          s_axis_b_tvalid = 1'b0, s_axis_b_tlast = 1'b0;
  logic [W-1:0]  s_axis_b_tdata = '0;
  logic [K-1:0]  s_axis_b_tkeep = '1;
  logic          s_axis_b_tready;
  logic          m_axis_c_tvalid, m_axis_c_tlast;
  logic [W-1:0]  m_axis_c_tdata;
  logic [K-1:0]  m_axis_c_tkeep;
  logic          m_axis_c_tready = 1'b0;
  logic          op_valid, op_sub;
  logic [W-1:0]  op_a, op_b;
  logic          res_valid;
  logic [W-1:0]  res_data;

  vadd_stream_seq dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start),
    .cfg_length(cfg_length), .cfg_sub(cfg_sub),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .status_len_err(status_len_err),
    .s_axis_a_tvalid(s_axis_a_tvalid), .s_axis_a_tdata(s_axis_a_tdata),
    .s_axis_a_tready(s_axis_a_tready), .s_axis_a_tkeep(s_axis_a_tkeep),
    .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_b_tvalid(s_axis_b_tvalid), .s_axis_b_tdata(s_axis_b_tdata),
    .s_axis_b_tready(s_axis_b_tready), .s_axis_b_tkeep(s_axis_b_tkeep),
    .s_axis_b_tlast(s_axis_b_tlast),
    .m_axis_c_tvalid(m_axis_c_tvalid), .m_axis_c_tdata(m_axis_c_tdata),
    .m_axis_c_tready(m_axis_c_tready), .m_axis_c_tkeep(m_axis_c_tkeep),
    .m_axis_c_tlast(m_axis_c_tlast),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .res_valid(res_valid), .res_data(res_data)
  );

  // ---------------- external operator model ----------------
  function automatic logic [W-1:0] lane_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [W-1:0] r;
    for (int l = 0; l < W / 32; l++)
      r[l*32 +: 32] = s ? (a[l*32 +: 32] - b[l*32 +: 32]) : (a[l*32 +: 32] + b[l*32 +: 32]);
    return r;
  endfunction

  // Fixed 4-stage pipeline; deliberately not reset so stale results can return.
  logic [3:0]   pv = '0;
  logic [W-1:0] pd [4];
  always @(posedge ap_clk) begin
    pv    <= {pv[2:0], op_valid};
    pd[0] <= lane_op(op_a, op_b, op_sub);
    for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
  end
  assign res_valid = pv[3];
  assign res_data  = pd[3];

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] src_a[$], src_b[$];
  bit           src_la[$], src_lb[$];
  int  a_idx, b_idx, out_n, issued, done_n;
  int  run_len;
  bit  run_sub, a_en, b_en, a_fire, b_fire;
  logic [W-1:0] cur_a, cur_b;

  typedef struct packed {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // ---------------- drivers ----------------
  task automatic drive();
    s_axis_a_tvalid = a_en && (a_idx < src_a.size());
    cur_a           = (a_idx < src_a.size()) ? src_a[a_idx] : '0;
    s_axis_a_tdata  = cur_a;
    s_axis_a_tlast  = (a_idx < src_la.size()) ? src_la[a_idx] : 1'b0;
    s_axis_b_tvalid = b_en && (b_idx < src_b.size());
    cur_b           = (b_idx < src_b.size()) ? src_b[b_idx] : '0;
    s_axis_b_tdata  = cur_b;
    s_axis_b_tlast  = (b_idx < src_lb.size()) ? src_lb[b_idx] : 1'b0;
  endtask

  // One clock: monitor at the falling edge, advance sources after the rising edge.
  task automatic step();
    logic [W-1:0] e;
    @(negedge ap_clk);
    if (op_valid || s_axis_a_tready || s_axis_b_tready) begin
      check("issue_handshake",
            {op_valid, s_axis_a_tready, s_axis_b_tready, s_axis_a_tvalid, s_axis_b_tvalid},
            5'b11111);
      check("op_a", op_a, cur_a);
      check("op_b", op_b, cur_b);
      check("op_sub", op_sub, run_sub);
      issued++;
    end
    if (m_axis_c_tvalid && m_axis_c_tready) begin
      out_n++;
      if (exp_q.size() == 0) fail_now("out_extra", "output beat with empty expected queue");
      else begin
        e = exp_q.pop_front();
        check("out_data", m_axis_c_tdata, e);
      end
      check("out_tlast", m_axis_c_tlast, (out_n == run_len));
      check("out_tkeep", m_axis_c_tkeep, {K{1'b1}});
    end
    if (ap_done) begin
      done_n++;
      check("ap_ready_with_done", ap_ready, 1'b1);
    end
    a_fire = s_axis_a_tvalid && s_axis_a_tready;
    b_fire = s_axis_b_tvalid && s_axis_b_tready;
    @(posedge ap_clk);
    #1;
    if (a_fire) a_idx++;
    if (b_fire) b_idx++;
    drive();
  endtask

  task automatic new_run();
    src_a.delete(); src_b.delete(); src_la.delete(); src_lb.delete();
    exp_q.delete();
    a_idx = 0; b_idx = 0; out_n = 0; issued = 0; done_n = 0;
    a_en = 1'b0; b_en = 1'b0;
    drive();
  endtask

  task automatic load_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit la, input bit lb, input logic [W-1:0] e);
    src_a.push_back(a); src_b.push_back(b);
    src_la.push_back(la); src_lb.push_back(lb);
    exp_q.push_back(e);
  endtask

  task automatic load_pattern(input int n, input bit s);
    logic [31:0] i32;
    logic [W-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      i32 = 32'(i + 1);
      a = {i32, i32 * 32'd3};
      b = {i32 * 32'd7, 32'h1};
      load_beat(a, b, (i == n - 1), (i == n - 1), lane_op(a, b, s));
    end
  endtask

  task automatic start(input int len, input bit s);
    run_len = len; run_sub = s;
    cfg_length = 32'(len); cfg_sub = s;
    ap_start = 1'b1;
    drive();
    step();
    ap_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int i = 0;
    while (done_n == 0 && i < budget) begin
      step();
      i++;
    end
    if (done_n == 0) fail_now({tag, "_timeout"}, "no ap_done within cycle budget");
    repeat (3) step();
    check({tag, "_done_pulses"}, done_n, 1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge ap_clk);
    check({tag, "_ap_idle"}, ap_idle, 1'b1);
    check({tag, "_ap_done"}, {ap_done, ap_ready}, 2'b00);
    check({tag, "_tready"}, {s_axis_a_tready, s_axis_b_tready}, 2'b00);
    check({tag, "_c_tvalid"}, m_axis_c_tvalid, 1'b0);
    check({tag, "_op_valid"}, op_valid, 1'b0);
    check({tag, "_len_err"}, status_len_err, 1'b0);
    @(posedge ap_clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Hand-computed vectors: lane-wise 32-bit add (0..7) and subtract (8..11).
    tbl[0]  = '{1'b0, 64'h00000001_00000002, 64'h00000010_00000020, 64'h00000011_00000022};
    tbl[1]  = '{1'b0, 64'h00000100_00000200, 64'h00000001_00000001, 64'h00000101_00000201};
    tbl[2]  = '{1'b0, 64'hFFFFFFFF_00000001, 64'h00000001_00000001, 64'h00000000_00000002};
    tbl[3]  = '{1'b0, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 64'h23456789_ABCDF001};
    tbl[4]  = '{1'b0, 64'h7FFFFFFF_80000000, 64'h00000001_80000000, 64'h80000000_00000000};
    tbl[5]  = '{1'b0, 64'h00000000_00000000, 64'h00000000_00000000, 64'h00000000_00000000};
    tbl[6]  = '{1'b0, 64'hDEADBEEF_CAFEF00D, 64'h00000000_00000000, 64'hDEADBEEF_CAFEF00D};
    tbl[7]  = '{1'b0, 64'h00000005_00000007, 64'h00000003_00000002, 64'h00000008_00000009};
    tbl[8]  = '{1'b1, 64'h00000010_00000020, 64'h00000001_00000002, 64'h0000000F_0000001E};
    tbl[9]  = '{1'b1, 64'h00000000_00000005, 64'h00000001_00000003, 64'hFFFFFFFF_00000002};
    tbl[10] = '{1'b1, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 64'h01234567_89ABCDDF};
    tbl[11] = '{1'b1, 64'h00000100_00000100, 64'h00000100_00000001, 64'h00000000_000000FF};

    new_run();
    repeat (3) step();
    check_idle("in_reset");
    areset = 1'b0;
    check_idle("after_reset");

    // 8-beat add run; a start edge with new config mid-run must be ignored.
    new_run();
    for (int i = 0; i < 8; i++)
      load_beat(tbl[i].a, tbl[i].b, (i == 7), (i == 7), tbl[i].c);
    a_en = 1'b1; b_en = 1'b1; m_axis_c_tready = 1'b1;
    start(8, tbl[0].sub);
    step();
    cfg_length = 32'd3; cfg_sub = 1'b1; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    run_until_done(100, "run8");
    check("run8_out_beats", out_n, 8);
    check("run8_issued", issued, 8);
    check("run8_exp_left", exp_q.size(), 0);
    check("run8_len_err", status_len_err, 1'b0);
    check("run8_idle", ap_idle, 1'b1);

    // Zero-length run: done pulse, no stream or operator activity.
    new_run();
    load_pattern(2, 1'b0);
    exp_q.delete();
    a_en = 1'b1; b_en = 1'b1;
    start(0, 1'b0);
    run_until_done(4, "len0");
    check("len0_issued", issued, 0);
    check("len0_a_idx", a_idx, 0);

    // b withheld: neither stream may be consumed until b is valid.
    new_run();
    load_pattern(2, 1'b1);
    a_en = 1'b1; b_en = 1'b0;
    start(2, 1'b1);
    repeat (6) step();
    check("bhold_issued", issued, 0);
    check("bhold_a_idx", a_idx, 0);
    b_en = 1'b1;
    drive();
    run_until_done(40, "bhold");
    check("bhold_out_beats", out_n, 2);

    // Subtract run with an early tlast on stream a at beat 2.
    new_run();
    for (int i = 8; i < 12; i++)
      load_beat(tbl[i].a, tbl[i].b, (i == 9) || (i == 11), (i == 11), tbl[i].c);
    a_en = 1'b1; b_en = 1'b1;
    start(4, tbl[8].sub);
    run_until_done(60, "lenerr");
    check("lenerr_flag", status_len_err, 1'b1);
    check("lenerr_out_beats", out_n, 4);

    // Backpressure: 40 beats with c stalled; issue must stop at FIFO depth.
    new_run();
    load_pattern(40, 1'b0);
    a_en = 1'b1; b_en = 1'b1; m_axis_c_tready = 1'b0;
    start(40, 1'b0);
    check("bp_len_err_cleared", status_len_err, 1'b0);
    repeat (60) step();
    check("bp_issued_stalled", issued, 16);
    check("bp_no_output", out_n, 0);
    m_axis_c_tready = 1'b1;
    run_until_done(400, "bp");
    check("bp_out_beats", out_n, 40);
    check("bp_exp_left", exp_q.size(), 0);

    // Reset on the third beat of an 8-beat run, then a clean 2-beat run.
    new_run();
    load_pattern(8, 1'b0);
    a_en = 1'b1; b_en = 1'b1;
    start(8, 1'b0);
    for (int i = 0; i < 50 && issued < 3; i++) step();
    check("rst_issued_before", issued, 3);
    areset = 1'b1;
    check_idle("rst_during");
    areset = 1'b0;
    new_run();
    check_idle("rst_after");
    repeat (10) step();
    check("rst_stale_outputs", out_n, 0);
    new_run();
    load_pattern(2, 1'b0);
    a_en = 1'b1; b_en = 1'b1;
    start(2, 1'b0);
    run_until_done(40, "rerun");
    check("rerun_out_beats", out_n, 2);
    check("rerun_exp_left", exp_q.size(), 0);
    check("rerun_len_err", status_len_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
